// File: rtl/ps2_ascii_decoder.sv
// ps2_ascii_decoder: PS/2 Set-2 scan-code receiver and decoder that queues ASCII characters for the video memory writer.
// Latency: with the queue empty, ascii_valid rises in cycle E+2, where E is the cycle that detects the stop-bit falling edge.
// Backpressure: ascii_ready holds the queue head; a character pushed while the queue is full is dropped and sets the sticky overflow flag.
// Optional feature macro: KBD_SHIFT_EN builds left/right Shift tracking so letters become upper case.
// Ports: clk, reset (synchronous, active-high); ps2_clk/ps2_data are asynchronous keyboard pins;
//        ascii/ascii_valid/ascii_ready form the queue head; frame_err is a one-cycle pulse; overflow is sticky.
module ps2_ascii_decoder #(
  parameter int FIFO_DEPTH = 8,
  parameter int TIMEOUT    = 50000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] ascii,
  output logic       ascii_valid,
  input  logic       ascii_ready,
  output logic       frame_err,
  output logic       overflow
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BRK, S_EXT, S_EXT_BRK} state_t;

  // Receiver state
  logic [2:0]    pclk_q, pclk_d;     // [0],[1] synchroniser, [2] previous value for edge detect
  logic [1:0]    pdat_q, pdat_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    shift_q, shift_d;   // start, d0..d7, parity after ten shifts (start at [0])
  logic [TW-1:0] idle_q, idle_d;
  logic [7:0]    code_q, code_d;
  logic          code_vld_q, code_vld_d;
  logic          frame_err_q, frame_err_d;
  logic          fall;

  // Decoder state
  state_t        state_q, state_d;
  logic          shift_act;
  logic          shift_key;
  logic          push;
  logic [7:0]    push_dat;
`ifdef KBD_SHIFT_EN
  logic          shl_q, shl_d, shr_q, shr_d;
`endif

  // Queue state
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [7:0]    mem_d [FIFO_DEPTH];
  logic [AW:0]   wr_q, wr_d, rd_q, rd_d;
  logic          ovf_q, ovf_d;
  logic          empty, full, pop, wr_en;

  function automatic logic [7:0] lut_ascii(input logic [7:0] code, input logic upper);
    logic [4:0] idx;
    logic       is_letter;
    logic [7:0] res;
    idx       = 5'd0;
    is_letter = 1'b1;
    res       = 8'h00;
    case (code)
      8'h1C: idx = 5'd0;   8'h32: idx = 5'd1;   8'h21: idx = 5'd2;   8'h23: idx = 5'd3;
      8'h24: idx = 5'd4;   8'h2B: idx = 5'd5;   8'h34: idx = 5'd6;   8'h33: idx = 5'd7;
      8'h43: idx = 5'd8;   8'h3B: idx = 5'd9;   8'h42: idx = 5'd10;  8'h4B: idx = 5'd11;
      8'h3A: idx = 5'd12;  8'h31: idx = 5'd13;  8'h44: idx = 5'd14;  8'h4D: idx = 5'd15;
      8'h15: idx = 5'd16;  8'h2D: idx = 5'd17;  8'h1B: idx = 5'd18;  8'h2C: idx = 5'd19;
      8'h3C: idx = 5'd20;  8'h2A: idx = 5'd21;  8'h1D: idx = 5'd22;  8'h22: idx = 5'd23;
      8'h35: idx = 5'd24;  8'h1A: idx = 5'd25;
      default: is_letter = 1'b0;
    endcase
    if (is_letter) res = (upper ? 8'h41 : 8'h61) + {3'b000, idx};
    case (code)
      8'h45: res = 8'h30;  8'h16: res = 8'h31;  8'h1E: res = 8'h32;  8'h26: res = 8'h33;
      8'h25: res = 8'h34;  8'h2E: res = 8'h35;  8'h36: res = 8'h36;  8'h3D: res = 8'h37;
      8'h3E: res = 8'h38;  8'h46: res = 8'h39;
      8'h29: res = 8'h20;  8'h5A: res = 8'h0A;  8'h66: res = 8'h08;
      default: ;
    endcase
    return res;
  endfunction

  assign fall = pclk_q[2] & ~pclk_q[1];

  // Receiver: frame assembly, validation and mid-frame timeout
  always_comb begin
    pclk_d      = {pclk_q[1:0], ps2_clk};
    pdat_d      = {pdat_q[0], ps2_data};
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    idle_d      = idle_q;
    code_d      = code_q;
    code_vld_d  = 1'b0;
    frame_err_d = 1'b0;
    if (fall) begin
      idle_d = '0;
      if (bit_cnt_q == 4'd10) begin
        // pdat_q[1] is the stop bit; odd parity over d7..d0 plus parity
        bit_cnt_d = 4'd0;
        if (!shift_q[0] && pdat_q[1] && (^shift_q[9:1])) begin
          code_d     = shift_q[8:1];
          code_vld_d = 1'b1;
        end else begin
          frame_err_d = 1'b1;
        end
      end else begin
        shift_d   = {pdat_q[1], shift_q[9:1]};
        bit_cnt_d = bit_cnt_q + 4'd1;
      end
    end else if (bit_cnt_q != 4'd0) begin
      if (idle_q == TW'(TIMEOUT - 1)) begin
        bit_cnt_d   = 4'd0;
        idle_d      = '0;
        frame_err_d = 1'b1;
      end else begin
        idle_d = idle_q + 1'b1;
      end
    end else begin
      idle_d = '0;
    end
  end

`ifdef KBD_SHIFT_EN
  assign shift_act = shl_q | shr_q;
`else
  assign shift_act = 1'b0;
`endif
  assign shift_key = (code_q == 8'h12) || (code_q == 8'h59);

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    if (code_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (code_q == 8'hF0)      state_d = S_BRK;
          else if (code_q == 8'hE0) state_d = S_EXT;
        end
        S_EXT:   state_d = (code_q == 8'hF0) ? S_EXT_BRK : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // FSM: outputs (queue push and shift tracking)
  always_comb begin
    push     = 1'b0;
    push_dat = lut_ascii(code_q, shift_act);
`ifdef KBD_SHIFT_EN
    shl_d = shl_q;
    shr_d = shr_q;
`endif
    if (code_vld_q) begin
      case (state_q)
        S_IDLE: begin
          if (shift_key) begin
`ifdef KBD_SHIFT_EN
            if (code_q == 8'h12) shl_d = 1'b1;
            else                 shr_d = 1'b1;
`endif
          end else if (code_q != 8'hF0 && code_q != 8'hE0) begin
            push = (push_dat != 8'h00);
          end
        end
        S_BRK: begin
`ifdef KBD_SHIFT_EN
          if (code_q == 8'h12) shl_d = 1'b0;
          if (code_q == 8'h59) shr_d = 1'b0;
`endif
        end
        default: ;
      endcase
    end
  end

  // Queue: a pop in the same cycle frees a slot for a push into a full queue
  assign empty = (wr_q == rd_q);
  assign full  = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign pop   = !empty && ascii_ready;
  assign wr_en = push && (!full || pop);

  always_comb begin
    mem_d = mem_q;
    if (wr_en) mem_d[wr_q[AW-1:0]] = push_dat;
    wr_d  = wr_en ? wr_q + 1'b1 : wr_q;
    rd_d  = pop ? rd_q + 1'b1 : rd_q;
    ovf_d = ovf_q | (push && full && !pop);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_q      <= 3'b111;
      pdat_q      <= 2'b11;
      bit_cnt_q   <= 4'd0;
      shift_q     <= '0;
      idle_q      <= '0;
      code_q      <= 8'h00;
      code_vld_q  <= 1'b0;
      frame_err_q <= 1'b0;
      mem_q       <= '{default: 8'h00};
      wr_q        <= '0;
      rd_q        <= '0;
      ovf_q       <= 1'b0;
`ifdef KBD_SHIFT_EN
      shl_q       <= 1'b0;
      shr_q       <= 1'b0;
`endif
    end else begin
      pclk_q      <= pclk_d;
      pdat_q      <= pdat_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      idle_q      <= idle_d;
      code_q      <= code_d;
      code_vld_q  <= code_vld_d;
      frame_err_q <= frame_err_d;
      mem_q       <= mem_d;
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      ovf_q       <= ovf_d;
`ifdef KBD_SHIFT_EN
      shl_q       <= shl_d;
      shr_q       <= shr_d;
`endif
    end
  end

  assign ascii       = empty ? 8'h00 : mem_q[rd_q[AW-1:0]];
  assign ascii_valid = !empty;
  assign frame_err   = frame_err_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_ps2_ascii_decoder.sv
`timescale 1ns/1ps
module tb_ps2_ascii_decoder;
  localparam int DEPTH = 8;
  localparam int TMO   = 400;
  localparam int HALF  = 50;   // ps2_clk period of 100 clk

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic       ascii_ready = 1'b1;
  logic [7:0] ascii;
  logic       ascii_valid;
  logic       frame_err;
  logic       overflow;

  int         checks = 0;
  int         failures = 0;
  int         pops = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_c;
  logic [4:1] vld_trace;
  logic [4:1] err_trace;

  always #5 clk = ~clk;

  ps2_ascii_decoder #(.FIFO_DEPTH(DEPTH), .TIMEOUT(TMO)) dut (
    .clk        (clk),
    .reset      (reset),
    .ps2_clk    (ps2_clk),
    .ps2_data   (ps2_data),
    .ascii      (ascii),
    .ascii_valid(ascii_valid),
    .ascii_ready(ascii_ready),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  // Scoreboard: every accepted character must match the oldest expected one
  always @(negedge clk) begin
    if (!reset && ascii_valid && ascii_ready) begin
      checks++;
      pops++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_char got=%h expected=none", ascii);
      end else begin
        exp_c = exp_q.pop_front();
        if (ascii !== exp_c) begin
          failures++;
          $display("FAIL char_value got=%h expected=%h", ascii, exp_c);
        end
      end
    end
  end

  task automatic frame_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  // Full frame; records ascii_valid/frame_err for the 4 negedges after the stop-bit fall
  task automatic send_frame(input logic [7:0] code, input logic bad_par);
    logic [10:0] f;
    f = {1'b1, (~^code) ^ bad_par, code, 1'b0};
    for (int i = 0; i < 10; i++) frame_bit(f[i]);
    @(negedge clk);
    ps2_data = 1'b1;
    repeat (HALF - 1) @(negedge clk);
    ps2_clk = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      vld_trace[k] = ascii_valid;
      err_trace[k] = frame_err;
    end
    repeat (HALF - 4) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 ascii_ready = r;
  endtask

  task automatic drain_check(input int p0, input int n, input string name);
    repeat (20) @(negedge clk);
    checks++;
    if (pops - p0 != n) begin
      failures++;
      $display("FAIL %s_count got=%0d expected=%0d", name, pops - p0, n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL %s_missing got_pending=%0d expected=0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (ascii_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b expected=0", ascii_valid); end
    checks++; if (ascii !== 8'h00) begin failures++; $display("FAIL reset_ascii got=%h expected=00", ascii); end
    checks++; if (frame_err !== 1'b0) begin failures++; $display("FAIL reset_frame_err got=%b expected=0", frame_err); end
    checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b expected=0", overflow); end
    reset = 1'b0;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_make_break();
    int p0;
    p0 = pops;
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0);
    checks++;
    if (vld_trace !== 4'b1000) begin
      failures++;
      $display("FAIL latency_valid_trace got=%b expected=1000", vld_trace);
    end
    send_frame(8'hF0, 1'b0);
    send_frame(8'h1C, 1'b0);
    drain_check(p0, 1, "make_break");
  endtask

  task automatic test_shift();
    int p0;
    p0 = pops;
`ifdef KBD_SHIFT_EN
    exp_q.push_back(8'h41);
`else
    exp_q.push_back(8'h61);
`endif
    exp_q.push_back(8'h61);
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h12, 1'b0);
    send_frame(8'h1C, 1'b0);
    drain_check(p0, 2, "shift");
  endtask

  task automatic test_bad_parity();
    int p0;
    p0 = pops;
    send_frame(8'h1C, 1'b1);
    checks++;
    if (err_trace !== 4'b0100) begin
      failures++;
      $display("FAIL parity_err_trace got=%b expected=0100", err_trace);
    end
    exp_q.push_back(8'h0A);
    send_frame(8'h5A, 1'b0);
    checks++;
    if (err_trace !== 4'b0000) begin
      failures++;
      $display("FAIL good_frame_err_trace got=%b expected=0000", err_trace);
    end
    drain_check(p0, 1, "bad_parity");
  endtask

  task automatic test_timeout();
    int p0;
    int errs;
    logic [10:0] f;
    p0   = pops;
    errs = 0;
    f    = {1'b1, ~^8'h45, 8'h45, 1'b0};
    for (int i = 0; i < 4; i++) frame_bit(f[i]);
    for (int c = 0; c < 2 * TMO; c++) begin
      @(negedge clk);
      if (frame_err) errs++;
    end
    checks++;
    if (errs != 1) begin
      failures++;
      $display("FAIL timeout_err_pulses got=%0d expected=1", errs);
    end
    exp_q.push_back(8'h30);
    send_frame(8'h45, 1'b0);
    drain_check(p0, 1, "timeout");
  endtask

  task automatic test_extended();
    int p0;
    p0 = pops;
    send_frame(8'hE0, 1'b0);
    send_frame(8'h75, 1'b0);
    send_frame(8'hE0, 1'b0);
    send_frame(8'hF0, 1'b0);
    send_frame(8'h75, 1'b0);
    exp_q.push_back(8'h31);
    send_frame(8'h16, 1'b0);
    exp_q.push_back(8'h61);
    send_frame(8'h1C, 1'b0);
    drain_check(p0, 2, "extended");
  endtask

  task automatic test_overflow();
    int p0;
    p0 = pops;
    set_ready(1'b0);
    for (int i = 0; i < 9; i++) begin
      if (i < DEPTH) exp_q.push_back(8'h20);
      send_frame(8'h29, 1'b0);
      if (i == DEPTH - 1) begin
        checks++;
        if (overflow !== 1'b0) begin failures++; $display("FAIL overflow_early got=%b expected=0", overflow); end
        checks++;
        if (ascii_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%b expected=1", ascii_valid); end
      end
    end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_set got=%b expected=1", overflow); end
    set_ready(1'b1);
    drain_check(p0, DEPTH, "overflow_drain");
    checks++;
    if (ascii_valid !== 1'b0) begin failures++; $display("FAIL drained_valid got=%b expected=0", ascii_valid); end
    checks++;
    if (overflow !== 1'b1) begin failures++; $display("FAIL overflow_sticky got=%b expected=1", overflow); end
  endtask

  initial begin
    test_reset();
    test_make_break();
    test_shift();
    test_bad_parity();
    test_timeout();
    test_extended();
    test_overflow();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ps2_ascii_decoder.md
# ps2_ascii_decoder

Receives raw PS/2 keyboard frames, decodes Set-2 scan codes into ASCII, and queues the characters for the text-mode video-memory writer. It sits directly upstream of the video memory block: its `ascii`/`ascii_valid` outputs drive that block's key data and valid inputs. It tracks make and break codes, the E0 prefix, and Shift. A small FIFO decouples keyboard bursts from the consumer.

## Interface
- `FIFO_DEPTH`, default 8: ASCII queue entries; must be a power of 2, ≥2.
- `TIMEOUT`, default 50000: idle clk cycles mid-frame before the partial frame is discarded.
- `clk`  in  1  system clock.
- `reset`  in  1  synchronous, active-high reset.
- `ps2_clk`  in  1  asynchronous PS/2 clock from the keyboard.
- `ps2_data`  in  1  asynchronous PS/2 data.
- `ascii`  out  8  head-of-queue character; valid only while `ascii_valid` is high.
- `ascii_valid`  out  1  queue non-empty.
- `ascii_ready`  in  1  consumer accepts; an entry pops on `ascii_valid && ascii_ready`. Tie high for the video memory, which then sees single-cycle valids.
- `frame_err`  out  1  one-cycle pulse when a frame is rejected or times out.
- `overflow`  out  1  sticky flag: a character was dropped because the queue was full. Cleared only by reset.

## Operation
- **Synchroniser.**
  - `ps2_clk` and `ps2_data` each pass through 2 flip-flops.
  - A third register on the clock path provides falling-edge detection: previous 1, current 0. This cycle is called E.
- **Receiver.**
  - Bit counter runs 0..10. On each E it shifts in the synchronised data.
  - Bit order: start, d0..d7 (LSB first), parity, stop.
  - On bit 10 the frame is accepted only if start=0, stop=1, and XOR(d7..d0, parity)=1 (odd parity).
  - Otherwise the frame is dropped and `frame_err` pulses.
  - The counter returns to 0 after bit 10 in all cases.
- **Timeout.**
  - While bit count ≠ 0, an idle counter increments every cycle and clears on each E.
  - When it reaches TIMEOUT-1: bit count goes to 0 and `frame_err` pulses.
- **Decoder FSM.** States are IDLE, BRK, EXT, EXT_BRK. Transitions on each accepted code:
  - IDLE:
    - F0 → BRK.
    - E0 → EXT.
    - 12 or 59 → set `shl` or `shr`; stay in IDLE, no output.
    - Any other code → look up ASCII; push if non-zero; stay in IDLE.
  - BRK: 12 or 59 clears the matching shift bit. Any code → IDLE. No output.
  - EXT: F0 → EXT_BRK; any other code → IDLE. Extended makes produce no output.
  - EXT_BRK: any code → IDLE.
  - Typematic repeat makes are pushed again.
- **Lookup table.**
  - Letters 1C,32,21,23,24,2B,34,33,43,3B,42,4B,3A,31,44,4D,15,2D,1B,2C,3C,2A,1D,22,35,1A map to 'a'..'z' (0x61..0x7A).
    - If `shl|shr` is set, they map to 'A'..'Z' (0x41..).
  - Digits 45,16,1E,26,25,2E,36,3D,3E,46 map to '0'..'9'; Shift does not affect them.
  - 29 → 0x20, 5A → 0x0A, 66 → 0x08.
  - All other codes map to 0, which is not pushed.
- **FIFO.**
  - Pointers are log2(FIFO_DEPTH)+1 bits wide and wrap naturally.
  - `ascii` reads combinationally from the read pointer.
  - Push while full: drop the character and set `overflow`.
  - Push and pop in the same cycle while full: the pop frees the slot and the push is accepted.
  - Push and pop in the same cycle while empty: no pop occurs; the push is accepted.
- **Reset.**
  - `ascii`=0, `ascii_valid`=0, `frame_err`=0, `overflow`=0.
  - FIFO empty, FSM in IDLE, shift bits cleared, bit and idle counters at 0.
  - Reset mid-frame discards the partial frame. Any remaining bits misalign the next frame; the timeout or parity/stop checks recover from this.

## Timing
- Fixed latency when the FIFO is empty:
  - Stop-bit edge detected in cycle E.
  - Scan code registered at the end of E.
  - FSM/lookup pushes at the end of E+1.
  - `ascii_valid` is high in cycle E+2.
- Synchroniser delay: 2–3 clk cycles from a `ps2_clk` pin transition to E.
- Throughput: one code per frame, far below the clk rate. The FSM never stalls.
- `frame_err` is high in cycle E+1 for bad frames, and in the cycle after the timeout hit for timeouts.

## Configuration
- `KBD_SHIFT_EN`
  - Defined: `shl`/`shr` tracking is built in and letters follow Shift as described above.
  - Undefined: no shift registers. Codes 12 and 59 (make and break) are consumed silently, and letters are always lowercase.

## Test plan
- Frames 1C, then F0 1C, with `ps2_clk` period 100 clk → exactly one `ascii`=0x61, `ascii_valid` high at E+2 of the first stop bit; the break frame produces nothing.
- 12, 1C, F0 12, 1C → outputs 0x41 then 0x61 (with `KBD_SHIFT_EN`); 0x61, 0x61 without it.
- 1C frame with parity bit inverted → `frame_err` pulse, no output; following 5A → 0x0A.
- `ascii_ready`=0 with FIFO_DEPTH=8, send 29 ×9 → `overflow`=1 after the 9th frame. Raise `ascii_ready` → exactly 8 × 0x20, then `ascii_valid`=0.
- Abort after 4 bits, idle TIMEOUT cycles → `frame_err` pulse. A full 45 frame then yields 0x30.
- E0 75, then E0 F0 75, then 16 → only 0x31 is output; FSM back in IDLE.
